// File: rtl/bip_debug_unit.sv
// UART-driven debug controller for the BIP CPU: program load, run/step/reset, PC/ACC/cycle report.
// Latency: one command byte per i_rx_done; registered prog-write 1 cycle after the last byte of a word.
// Backpressure: each tx byte waits for i_tx_done; rx bytes outside IDLE/LD_* dropped (RUN treats them as abort).
module bip_debug_unit #(
    parameter int         NB_INSTRUC = 16,
    parameter int         NB_ADDR    = 11,
    parameter int         NB_DATA    = 16,
    parameter int         NB_CYCLES  = 32,
    parameter int         PROG_DEPTH = 2048,
    parameter logic [7:0] ACK_BYTE   = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_prog_we,
    output logic [NB_ADDR-1:0]    o_prog_addr,
    output logic [NB_INSTRUC-1:0] o_prog_data,
    output logic                  o_cpu_en,
    output logic                  o_cpu_rst,
    input  logic [NB_ADDR-1:0]    i_pc,
    input  logic [NB_DATA-1:0]    i_acc,
    input  logic                  i_halt
);

    localparam int NBY_I = (NB_INSTRUC + 7) / 8;
    localparam int NBY_A = (NB_ADDR + 7) / 8;
    localparam int NBY_D = (NB_DATA + 7) / 8;
    localparam int NBY_C = (NB_CYCLES + 7) / 8;
    localparam int NBY_T = NBY_A + NBY_D + NBY_C;
    localparam int W_I   = 8 * NBY_I;
    localparam int W_A   = 8 * NBY_A;
    localparam int W_D   = 8 * NBY_D;
    localparam int W_C   = 8 * NBY_C;
    localparam int W_R   = 8 * NBY_T;
    localparam int BI_W  = $clog2(NBY_I + 1);
    localparam int RI_W  = $clog2(NBY_T + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_CNT, S_LD_DATA, S_CPU_RST, S_ACK_SEND, S_ACK_WAIT,
        S_RUN, S_STEP, S_REP_SNAP, S_REP_SEND, S_REP_WAIT
    } state_t;

    state_t               state, state_nxt;
    logic [15:0]          word_cnt;
    logic [15:0]          word_idx;
    logic                 cnt_byte;
    logic [BI_W-1:0]      byte_idx;
    logic [W_I-1:0]       word_sr;
    logic [W_I-1:0]       word_full;
    logic                 last_byte;
    logic [W_R-1:0]       snap;
    logic [RI_W-1:0]      rep_idx;
    logic [NB_CYCLES-1:0] cyc_cnt;

    assign last_byte = (byte_idx == BI_W'(NBY_I - 1));

    // Current word with the incoming byte merged into its lane
    always_comb begin
        word_full = word_sr;
        word_full[byte_idx*8 +: 8] = i_rx_data;
    end

    // CPU enable is gated by halt in the same cycle so a halted CPU never gets an extra tick
    assign o_cpu_en   = ((state == S_RUN) || (state == S_STEP)) && !i_halt;
    assign o_cpu_rst  = (state == S_CPU_RST);
    assign o_tx_start = (state == S_ACK_SEND) || (state == S_REP_SEND);
    assign o_tx_data  = ((state == S_ACK_SEND) || (state == S_ACK_WAIT)) ? ACK_BYTE :
                        ((state == S_REP_SEND) || (state == S_REP_WAIT)) ? snap[7:0] : 8'h00;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: command decode, load sequencing, run/step exit, report byte walk
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        8'h01:   state_nxt = S_LD_CNT;
                        8'h02:   state_nxt = S_RUN;
                        8'h03:   state_nxt = S_STEP;
                        8'h04:   state_nxt = S_REP_SNAP;
                        8'h05:   state_nxt = S_CPU_RST;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LD_CNT: begin
                if (i_rx_done && cnt_byte)
                    state_nxt = ({i_rx_data, word_cnt[7:0]} == 16'd0) ? S_ACK_SEND : S_LD_DATA;
            end
            S_LD_DATA: begin
                if (i_rx_done && last_byte && (word_idx == word_cnt - 16'd1))
                    state_nxt = S_CPU_RST;
            end
            S_CPU_RST:  state_nxt = S_ACK_SEND;
            S_ACK_SEND: state_nxt = S_ACK_WAIT;
            S_ACK_WAIT: if (i_tx_done) state_nxt = S_IDLE;
            S_RUN:      if (i_halt || i_rx_done) state_nxt = S_REP_SNAP;
            S_STEP:     state_nxt = S_REP_SNAP;
            S_REP_SNAP: state_nxt = S_REP_SEND;
            S_REP_SEND: state_nxt = S_REP_WAIT;
            S_REP_WAIT: begin
                if (i_tx_done)
                    state_nxt = (rep_idx == RI_W'(NBY_T - 1)) ? S_IDLE : S_REP_SEND;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Load path: word count capture, byte assembly and the registered program-memory write
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_cnt    <= '0;
            word_idx    <= '0;
            cnt_byte    <= 1'b0;
            byte_idx    <= '0;
            word_sr     <= '0;
            o_prog_we   <= 1'b0;
            o_prog_addr <= '0;
            o_prog_data <= '0;
        end else begin
            o_prog_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_done && (i_rx_data == 8'h01)) begin
                        cnt_byte <= 1'b0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        word_sr  <= '0;
                    end
                end
                S_LD_CNT: begin
                    if (i_rx_done) begin
                        if (!cnt_byte) word_cnt[7:0]  <= i_rx_data;
                        else           word_cnt[15:8] <= i_rx_data;
                        cnt_byte <= ~cnt_byte;
                    end
                end
                S_LD_DATA: begin
                    if (i_rx_done) begin
                        if (last_byte) begin
                            // Out-of-range words are consumed but never written
                            o_prog_we   <= (32'(word_idx) < PROG_DEPTH);
                            o_prog_addr <= NB_ADDR'(word_idx);
                            o_prog_data <= word_full[NB_INSTRUC-1:0];
                            word_idx    <= word_idx + 16'd1;
                            byte_idx    <= '0;
                            word_sr     <= '0;
                        end else begin
                            word_sr  <= word_full;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Report path: snapshot taken one cycle after RUN/STEP ends, when the CPU is already frozen
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            snap    <= '0;
            rep_idx <= '0;
        end else if (state == S_REP_SNAP) begin
            snap    <= {W_C'(cyc_cnt), W_D'(i_acc), W_A'(i_pc)};
            rep_idx <= '0;
        end else if ((state == S_REP_WAIT) && i_tx_done) begin
            snap    <= snap >> 8;
            rep_idx <= rep_idx + 1'b1;
        end
    end

    // Saturating count of enabled CPU cycles, cleared with every CPU reset pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            cyc_cnt <= '0;
        else if (state == S_CPU_RST)
            cyc_cnt <= '0;
        else if (o_cpu_en && (cyc_cnt != '1))
            cyc_cnt <= cyc_cnt + 1'b1;
    end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: load, step, run/halt, run/abort, unknown command, reset mid-load.
// Program depth is shrunk to 3 so the out-of-range write suppression can be exercised cheaply.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_bip_debug_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic        prog_we;
    logic [10:0] prog_addr;
    logic [15:0] prog_data;
    logic        cpu_en;
    logic        cpu_rst;
    logic [10:0] pc = 11'd0;
    logic [15:0] acc = 16'd0;
    logic        halt = 1'b0;

    int checks = 0;
    int errors = 0;

    bip_debug_unit #(.PROG_DEPTH(3)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_prog_we(prog_we), .o_prog_addr(prog_addr), .o_prog_data(prog_data),
        .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst),
        .i_pc(pc), .i_acc(acc), .i_halt(halt)
    );

    always #5 clk = ~clk;

    // Passive monitor of write pulses, reset pulses, enabled cycles and tx starts
    logic [10:0] we_addr[$];
    logic [15:0] we_data[$];
    int rst_pulses = 0, en_cycles = 0, tx_starts = 0, overlap = 0;
    always @(negedge clk) begin
        if (prog_we) begin
            we_addr.push_back(prog_addr);
            we_data.push_back(prog_data);
        end
        if (cpu_rst)  rst_pulses++;
        if (cpu_en)   en_cycles++;
        if (tx_start) tx_starts++;
        if (cpu_en && (tx_start || prog_we)) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic expect_tx(input logic [7:0] exp, input string tag);
        int t = 0;
        while (!tx_start && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s start", tag), 64'(tx_start), 64'd1);
        if (tx_start) chk($sformatf("%s data", tag), 64'(tx_data), 64'(exp));
        @(negedge clk);
        chk($sformatf("%s pulse", tag), 64'(tx_start), 64'd0);
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Eight report bytes, byte 0 in bits [7:0]
    task automatic expect_report(input logic [63:0] exp, input string tag);
        for (int i = 0; i < 8; i++)
            expect_tx(exp[8*i +: 8], $sformatf("%s b%0d", tag, i));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({tx_data, tx_start, prog_we, prog_addr, prog_data, cpu_en, cpu_rst});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r0, e0, t0, n, t;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // 1: LOAD three words
        base = we_addr.size();
        r0   = rst_pulses;
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h08);
        send_byte(8'h02); send_byte(8'h18);
        send_byte(8'h00); send_byte(8'h00);
        expect_tx(8'hA5, "load ack");
        chk("load we count", 64'(we_addr.size() - base), 64'd3);
        if (we_addr.size() >= base + 3) begin
            chk("load addr0", 64'(we_addr[base]),   64'd0);
            chk("load data0", 64'(we_data[base]),   64'h0801);
            chk("load addr1", 64'(we_addr[base+1]), 64'd1);
            chk("load data1", 64'(we_data[base+1]), 64'h1802);
            chk("load addr2", 64'(we_addr[base+2]), 64'd2);
            chk("load data2", 64'(we_data[base+2]), 64'h0000);
        end
        chk("load cpu_rst", 64'(rst_pulses - r0), 64'd1);

        // 2: STEP
        pc  = 11'd0;
        acc = 16'd0;
        e0  = en_cycles;
        send_byte(8'h03);
        expect_report(64'h00000001_0000_0000, "step");
        chk("step en cycles", 64'(en_cycles - e0), 64'd1);

        // 3: RUN, halt after 4 more enabled cycles
        pc  = 11'd5;
        acc = 16'h1234;
        e0  = en_cycles;
        send_byte(8'h02);
        n = 0; t = 0;
        while (n < 4 && t < 50) begin
            if (cpu_en) n++;
            if (n < 4) begin
                @(negedge clk);
                t++;
            end
        end
        chk("run en seen", 64'(n), 64'd4);
        @(posedge clk);
        #1 halt = 1'b1;
        expect_report(64'h00000005_1234_0005, "run halt");
        halt = 1'b0;
        chk("run en cycles", 64'(en_cycles - e0), 64'd4);

        // 4: CPU_RST, then RUN aborted by a byte after 100 cycles
        r0 = rst_pulses;
        send_byte(8'h05);
        expect_tx(8'hA5, "cpurst ack");
        chk("cpurst pulse", 64'(rst_pulses - r0), 64'd1);
        pc  = 11'h07F;
        acc = 16'hBEEF;
        e0  = en_cycles;
        send_byte(8'h02);
        n = 0; t = 0;
        while (n < 100 && t < 300) begin
            if (cpu_en) n++;
            if (n < 100) begin
                @(negedge clk);
                t++;
            end
        end
        chk("abort en seen", 64'(n), 64'd100);
        rx_data = 8'h00;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        chk("abort en low", 64'(cpu_en), 64'd0);
        expect_report(64'h00000064_BEEF_007F, "abort");
        chk("abort en cycles", 64'(en_cycles - e0), 64'd100);

        // 5: unknown command ignored, REPORT answered
        t0 = tx_starts;
        send_byte(8'h7E);
        repeat (10) @(negedge clk);
        chk("unknown no tx", 64'(tx_starts - t0), 64'd0);
        pc  = 11'h123;
        acc = 16'h00FF;
        send_byte(8'h04);
        expect_report(64'h00000064_00FF_0123, "report");

        // 6: reset in the middle of the second word
        base = we_addr.size();
        r0   = rst_pulses;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        #2 rst_n = 1'b0;
        #1 chk("midreset outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset we count", 64'(we_addr.size() - base), 64'd1);
        if (we_addr.size() >= base + 1) begin
            chk("midreset addr", 64'(we_addr[base]), 64'd0);
            chk("midreset data", 64'(we_data[base]), 64'h2211);
        end
        chk("midreset no cpu_rst", 64'(rst_pulses - r0), 64'd0);
        send_byte(8'h04);
        expect_report(64'h00000000_00FF_0123, "post reset");

        // 7: LOAD with N=0 acks immediately
        base = we_addr.size();
        r0   = rst_pulses;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        expect_tx(8'hA5, "n0 ack");
        chk("n0 no we", 64'(we_addr.size() - base), 64'd0);
        chk("n0 no cpu_rst", 64'(rst_pulses - r0), 64'd0);

        // 8: LOAD of 4 words into a 3-word memory drops the last write
        base = we_addr.size();
        r0   = rst_pulses;
        send_byte(8'h01); send_byte(8'h04); send_byte(8'h00);
        for (int w = 1; w <= 4; w++) begin
            send_byte(8'(w));
            send_byte(8'h00);
        end
        expect_tx(8'hA5, "depth ack");
        chk("depth we count", 64'(we_addr.size() - base), 64'd3);
        if (we_addr.size() >= base + 3) begin
            chk("depth addr2", 64'(we_addr[base+2]), 64'd2);
            chk("depth data2", 64'(we_data[base+2]), 64'h0003);
        end
        chk("depth cpu_rst", 64'(rst_pulses - r0), 64'd1);

        chk("no en overlap", 64'(overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
